// File: rtl/booth_inverse_divider.sv
// Iterative signed divider: restoring division on operand magnitudes, one quotient bit per
// clock, followed by a sign fix-up cycle. Companion to the Booth array multiplier.
module booth_inverse_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    // Magnitude of the most-negative value is 2^(WIDTH-1), which is exact as unsigned.
    assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_abs  = divisor[WIDTH-1] ? -divisor : divisor;

    assign shifted = {a_q, q_q[WIDTH-1]};
    assign diff    = shifted - {2'b00, m_q};
    assign fits    = ~diff[WIDTH+1];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        count_d     = count_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        sign_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_d = dividend[WIDTH-1];
                        q_d      = dividend_abs;
                        m_d      = divisor_abs;
                        a_d      = '0;
                        count_d  = CntW'(WIDTH);
                        busy_d   = 1'b1;
                        dbz_d    = 1'b0;
                        ovf_d    = 1'b0;
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                // Restore on borrow by simply keeping the shifted partial remainder.
                a_d     = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
                q_d     = {q_q[WIDTH-2:0], fits};
                count_d = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                quotient_d  = sign_q_q ? -q_q : q_q;
                remainder_d = sign_r_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
                // Only most-negative / -1 yields a positive magnitude with the top bit set.
                ovf_d       = ~sign_q_q & q_q[WIDTH-1];
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            count_q     <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            count_q     <= count_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_inverse_divider.sv
// Scoreboard bench for booth_inverse_divider at WIDTH=4: the driver queues expected results,
// an independent monitor checks every done pulse, its timing and the busy window length.
module tb_booth_inverse_divider;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errs = 0;
    int   cyc = 0;

    booth_inverse_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and measures busy windows.
    initial begin
        int run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                run = 0;
            end else begin
                if (busy) begin
                    run++;
                end else if (run != 0) begin
                    check("busy_len", run, W + 1);
                    run = 0;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("quotient", int'(quotient), int'(e.q));
                        check("remainder", int'(remainder), int'(e.r));
                        check("div_by_zero", int'(div_by_zero), int'(e.dbz));
                        check("overflow", int'(overflow), int'(e.ovf));
                        check("done_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    // Must be called at a negedge; drives one start pulse and queues its expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input logic eovf);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        e.ovf = eovf;
        e.cyc = cyc + 1 + (edbz ? 0 : W + 1);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (edbz) begin
            check("dbz_busy", int'(busy), 0);
        end else begin
            check("e0_busy", int'(busy), 1);
            check("e0_dbz_clear", int'(div_by_zero), 0);
            check("e0_ovf_clear", int'(overflow), 0);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 40) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (k >= 40) begin
            checks++;
            errs++;
            $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input logic eovf);
        @(negedge clk);
        issue(a, b, eq, er, edbz, eovf);
        wait_idle();
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        check("rst_ovf", int'(overflow), 0);
    endtask

    initial begin
        int k;
        int sa, sb_i, mq, mr;
        logic [W-1:0] ta, tb_v;
        logic [W-1:0] qv, rv;
        logic dz, ov;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Directed vectors, expectations worked by hand.
        run_op(4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0);  //  7 /  2
        run_op(4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0);  // -7 /  2
        run_op(4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0);  //  7 / -2
        run_op(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1);  // -8 / -1
        run_op(4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0);  // -8 /  1
        run_op(4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0);  //  5 /  0
        run_op(4'b0000, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0);  //  0 /  3
        run_op(4'b1010, 4'b0100, 4'b1111, 4'b1110, 1'b0, 1'b0);  // -6 /  4
        run_op(4'b1000, 4'b0011, 4'b1110, 4'b1110, 1'b0, 1'b0);  // -8 /  3
        run_op(4'b0111, 4'b1000, 4'b0000, 4'b0111, 1'b0, 1'b0);  //  7 / -8
        run_op(4'b1000, 4'b1000, 4'b0001, 4'b0000, 1'b0, 1'b0);  // -8 / -8

        // start mid-CALC with other operands must be ignored.
        @(negedge clk);
        issue(4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        dividend = 4'b0011;
        divisor  = 4'b0001;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Back-to-back: second start issued in the done cycle of the first.
        @(negedge clk);
        issue(4'b0110, 4'b0010, 4'b0011, 4'b0000, 1'b0, 1'b0);  //  6 / 2
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            checks++;
            errs++;
            $display("FAIL b2b_wait: done not seen within %0d cycles, expected it", k);
        end
        issue(4'b1011, 4'b0011, 4'b1111, 4'b1110, 1'b0, 1'b0);  // -5 / 3
        wait_idle();

        // Reset sampled at E2 of 6 / 3 aborts it without a done pulse.
        @(negedge clk);
        dividend = 4'b0110;
        divisor  = 4'b0011;
        start    = 1'b1;
        @(negedge clk);          // E0 passed
        start = 1'b0;
        @(negedge clk);          // E1 passed
        rst = 1'b1;
        @(negedge clk);          // E2 applied reset
        check_reset_outputs();
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_op(4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0);

        // Sweep of every operand pair against a truncating reference.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ta   = a[W-1:0];
                tb_v = b[W-1:0];
                sa   = int'($signed(ta));
                sb_i = int'($signed(tb_v));
                dz   = 1'b0;
                ov   = 1'b0;
                if (sb_i == 0) begin
                    qv = '1;
                    rv = ta;
                    dz = 1'b1;
                end else if (sa == -8 && sb_i == -1) begin
                    qv = 4'b1000;
                    rv = '0;
                    ov = 1'b1;
                end else begin
                    mq = sa / sb_i;
                    mr = sa % sb_i;
                    qv = mq[W-1:0];
                    rv = mr[W-1:0];
                end
                run_op(ta, tb_v, qv, rv, dz, ov);
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule

// File: doc/booth_inverse_divider.md
Name: booth_inverse_divider

Overview:
- Iterative signed two's-complement divider; the inverse operation to the team's Booth array multiplier.
- Recovers quotient and remainder from a product-style dividend and a divisor, one quotient bit per clock, using restoring division on magnitudes followed by a sign fix-up.
- Sits beside the multiplier in the arithmetic datapath.
- Start/busy/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits (two's complement); legal range 2..32.

Ports:
- clk  input  1  rising-edge clock, only clock of the block.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; captured on the accepted start edge.
- divisor  input  WIDTH  signed divisor; captured on the accepted start edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; takes the sign of the dividend.
- div_by_zero  output  1  divisor was zero for the last completed operation.
- overflow  output  1  quotient not representable for the last completed operation.

Behaviour:
- Reset values: busy, done, quotient, remainder, div_by_zero and overflow all 0. State is IDLE and the iteration counter is 0.
- Reset is synchronous and wins over everything.
  - Reset mid-operation aborts the division.
  - No done pulse is produced for the aborted division.
  - All outputs go to their reset values on that edge.
- States: IDLE, CALC, FIX.
- IDLE with start=1 and divisor!=0 (edge E0):
  - Latch sign_q = dividend sign XOR divisor sign.
  - Latch sign_r = dividend sign.
  - Latch |dividend| into Q and |divisor| into M, both WIDTH-bit unsigned. |most-negative| = 2^(WIDTH-1) fits.
  - Clear accumulator A (WIDTH+1 bits).
  - count <= WIDTH; busy <= 1; clear div_by_zero and overflow; go to CALC.
- CALC, one iteration per edge (E1..E_WIDTH):
  - Shift {A,Q} left by 1.
  - Compute A - M.
  - If the result is non-negative: A takes the result and Q[0] = 1.
  - Otherwise: A is unchanged (restored) and Q[0] = 0.
  - Decrement count. When count reaches 1 on this edge, the next state is FIX.
- FIX (edge E_WIDTH+1):
  - quotient <= sign_q ? -Q : Q.
  - remainder <= sign_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
  - overflow <= 1 if !sign_q and Q[WIDTH-1]=1. This occurs only for most-negative / -1; the quotient then wraps to most-negative.
  - done <= 1; busy <= 0; go to IDLE.
- Latency: done is high in the cycle after edge E_WIDTH+1, i.e. WIDTH+1 edges after the start edge.
  - busy is high for exactly WIDTH+1 cycles.
  - done falls on the following edge.
- Divide by zero (IDLE, start=1, divisor=0) on E0:
  - quotient <= all ones; remainder <= dividend.
  - div_by_zero <= 1; overflow <= 0; done <= 1.
  - Stay in IDLE; busy never asserts.
- start while busy is ignored; operands are not re-captured.
- start in the same cycle done is high is accepted, because the state is IDLE. done then drops on the next edge while busy rises.
- Outputs hold their last values until the next completion or reset. They are not cleared on a new start, except the two flags, which clear on E0.
- Zero dividend: quotient 0, remainder 0, flags 0, normal latency.
- The result must equal the truncating signed / and % on WIDTH-bit operands for all non-exceptional cases.

Test Plan:
- WIDTH=4, 7 / 2 -> quotient 0011, remainder 0001, flags 0, done exactly 5 edges after the start edge, busy high for 5 cycles.
- -7 / 2 and 7 / -2 -> quotient 1101 and remainder 1111 for the first; quotient 1101 and remainder 0001 for the second; flags 0.
- -8 / -1 -> quotient 1000, remainder 0000, overflow=1. Then -8 / 1 -> quotient 1000, overflow=0.
- 5 / 0 -> done one cycle after start, busy never 1, quotient 1111, remainder 0101, div_by_zero=1. The next valid op clears div_by_zero on its start edge.
- start pulsed mid-CALC with different operands -> ignored, first result unchanged. Back-to-back start in the done cycle -> second result is correct with the same latency.
- rst asserted at E2 of 6 / 3 -> no done pulse, all outputs 0 next cycle, new start afterwards completes normally. Also run an exhaustive sweep of all 256 WIDTH=4 pairs against a reference model.
